// File: rtl/fdd_track_writeback.sv
// Dirty-sector tracker and SD write-back engine for the floppy track buffer.
// Marks sectors touched by the disk controller and streams them back to the image on flush.
module fdd_track_writeback #(
    parameter int SECTORS     = 13,
    parameter int IDLE_CYCLES = 1000000,
    parameter int CNT_W       = 24
) (
    input  logic                CLK_VIDEO,
    input  logic                reset,
    input  logic [5:0]          track,
    input  logic                fd_write_disk,
    input  logic [13:0]         fd_track_addr,
    input  logic                fdd_mounted,
    input  logic                img_readonly,
    input  logic                flush_req,
    output logic                flush_done,
    output logic [31:0]         sd_lba,
    output logic                sd_wr,
    input  logic                sd_ack,
    output logic [3:0]          wb_sector,
    output logic [SECTORS-1:0]  dirty,
    output logic                cpu_wait
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_REQ,
        S_XFER,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] IDLE_LAST = CNT_W'(IDLE_CYCLES - 1);

    state_t               state_q, state_d;
    logic [SECTORS-1:0]   dirty_q, dirty_d;
    logic [5:0]           wb_track_q, wb_track_d;
    logic [CNT_W-1:0]     idle_cnt_q, idle_cnt_d;
    logic [3:0]           wb_sector_q, wb_sector_d;
    logic [31:0]          sd_lba_q, sd_lba_d;
    logic                 ack_prev_q, ack_prev_d;

    logic [3:0]           wr_sector;
    logic                 wr_hit;
    logic [SECTORS-1:0]   set_mask;
    logic [SECTORS-1:0]   clr_mask;
    logic                 ack_rise;
    logic                 ack_fall;
    logic                 idle_trig;
    logic [3:0]           low_idx;
    logic                 unused_addr;

    assign unused_addr = ^{fd_track_addr[13], fd_track_addr[8:0]};

    assign wr_sector = fd_track_addr[12:9];
    assign wr_hit    = fd_write_disk && (int'(wr_sector) < SECTORS);
    assign ack_rise  = sd_ack && !ack_prev_q;
    assign ack_fall  = !sd_ack && ack_prev_q;

    // The timer only runs while something is dirty and the controller is quiet.
    assign idle_trig = (state_q == S_IDLE) && (dirty_q != '0) && !fd_write_disk
                       && (idle_cnt_q == IDLE_LAST);

    always_comb begin
        set_mask = '0;
        for (int i = 0; i < SECTORS; i++) begin
            if (wr_hit && (wr_sector == 4'(i))) set_mask[i] = 1'b1;
        end
    end

    // Descending scan so the last hit is the lowest dirty index.
    always_comb begin
        low_idx = '0;
        for (int i = SECTORS - 1; i >= 0; i--) begin
            if (dirty_q[i]) low_idx = 4'(i);
        end
    end

    always_comb begin
        idle_cnt_d = idle_cnt_q;
        if (fd_write_disk || (dirty_q == '0)) begin
            idle_cnt_d = '0;
        end else if (state_q == S_IDLE) begin
            idle_cnt_d = idle_trig ? '0 : idle_cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        state_d     = state_q;
        clr_mask    = '0;
        wb_sector_d = wb_sector_q;
        sd_lba_d    = sd_lba_q;
        ack_prev_d  = sd_ack;
        case (state_q)
            S_IDLE: begin
                if (flush_req || idle_trig) state_d = S_SCAN;
            end
            S_SCAN: begin
                if (dirty_q == '0) begin
                    state_d = S_DONE;
                end else if (!fdd_mounted || img_readonly) begin
                    clr_mask = '1;
                    state_d  = S_DONE;
                end else begin
                    wb_sector_d = low_idx;
                    sd_lba_d    = 32'(wb_track_q) * 32'(SECTORS) + 32'(low_idx);
                    state_d     = S_REQ;
                end
            end
            S_REQ: begin
                if (ack_rise) begin
                    for (int i = 0; i < SECTORS; i++) begin
                        if (wb_sector_q == 4'(i)) clr_mask[i] = 1'b1;
                    end
                    state_d = S_XFER;
                end
            end
            S_XFER: begin
                if (ack_fall) state_d = S_SCAN;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // A controller write in the same cycle as a clear wins, so the sector goes out again.
    always_comb begin
        dirty_d    = (dirty_q & ~clr_mask) | set_mask;
        wb_track_d = wb_track_q;
        if (wr_hit && (dirty_q == '0)) wb_track_d = track;
    end

    always_ff @(posedge CLK_VIDEO) begin
        if (reset) begin
            state_q     <= S_IDLE;
            dirty_q     <= '0;
            wb_track_q  <= '0;
            idle_cnt_q  <= '0;
            wb_sector_q <= '0;
            sd_lba_q    <= '0;
            ack_prev_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            dirty_q     <= dirty_d;
            wb_track_q  <= wb_track_d;
            idle_cnt_q  <= idle_cnt_d;
            wb_sector_q <= wb_sector_d;
            sd_lba_q    <= sd_lba_d;
            ack_prev_q  <= ack_prev_d;
        end
    end

    assign sd_wr      = (state_q == S_REQ);
    assign cpu_wait   = (state_q != S_IDLE);
    assign flush_done = (state_q == S_DONE);
    assign sd_lba     = sd_lba_q;
    assign wb_sector  = wb_sector_q;
    assign dirty      = dirty_q;

endmodule

// File: tb/tb_fdd_track_writeback.sv
// Bench for fdd_track_writeback: directed scenarios plus random traffic against a
// cycle-level behavioural model and a reactive SD responder.
module tb_fdd_track_writeback;

    localparam int IDLE = 8;

    logic        CLK_VIDEO = 1'b0;
    logic        reset;
    logic [5:0]  track;
    logic        fd_write_disk;
    logic [13:0] fd_track_addr;
    logic        fdd_mounted;
    logic        img_readonly;
    logic        flush_req;
    logic        flush_done;
    logic [31:0] sd_lba;
    logic        sd_wr;
    logic        sd_ack;
    logic [3:0]  wb_sector;
    logic [12:0] dirty;
    logic        cpu_wait;

    fdd_track_writeback #(.SECTORS(13), .IDLE_CYCLES(IDLE), .CNT_W(24)) dut (
        .CLK_VIDEO    (CLK_VIDEO),
        .reset        (reset),
        .track        (track),
        .fd_write_disk(fd_write_disk),
        .fd_track_addr(fd_track_addr),
        .fdd_mounted  (fdd_mounted),
        .img_readonly (img_readonly),
        .flush_req    (flush_req),
        .flush_done   (flush_done),
        .sd_lba       (sd_lba),
        .sd_wr        (sd_wr),
        .sd_ack       (sd_ack),
        .wb_sector    (wb_sector),
        .dirty        (dirty),
        .cpu_wait     (cpu_wait)
    );

    always #5 CLK_VIDEO = ~CLK_VIDEO;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Behavioural model: phase 0 idle, 1 pick sector, 2 awaiting ack, 3 awaiting ack drop, 4 done.
    int          m_phase, m_track, m_cnt, m_sec;
    logic [12:0] m_dirty;
    logic [31:0] m_lba;
    logic        m_prev_ack;

    task automatic model_step();
        int s, old_phase;
        bit set, trig;
        logic [12:0] nd;
        if (reset) begin
            m_phase = 0; m_dirty = '0; m_track = 0; m_cnt = 0;
            m_sec = 0; m_lba = '0; m_prev_ack = 1'b0;
            return;
        end
        s    = int'(fd_track_addr[12:9]);
        set  = fd_write_disk && (s < 13);
        trig = (m_phase == 0) && (m_dirty != 0) && !fd_write_disk && (m_cnt == IDLE - 1);
        nd   = m_dirty;
        old_phase = m_phase;
        case (m_phase)
            0: if (flush_req || trig) m_phase = 1;
            1: begin
                if (m_dirty == 0) m_phase = 4;
                else if (!fdd_mounted || img_readonly) begin nd = '0; m_phase = 4; end
                else begin
                    for (int i = 12; i >= 0; i--) if (m_dirty[i]) m_sec = i;
                    m_lba   = 32'(13 * m_track + m_sec);
                    m_phase = 2;
                end
            end
            2: if (sd_ack && !m_prev_ack) begin nd[m_sec] = 1'b0; m_phase = 3; end
            3: if (!sd_ack && m_prev_ack) m_phase = 1;
            default: m_phase = 0;
        endcase
        if (fd_write_disk || m_dirty == 0) m_cnt = 0;
        else if (old_phase == 0) m_cnt = trig ? 0 : m_cnt + 1;
        if (set && m_dirty == 0) m_track = int'(track);
        if (set) nd[s] = 1'b1;
        m_dirty    = nd;
        m_prev_ack = sd_ack;
    endtask

    // SD responder state and transfer log
    int          rsp_delay = 4, rsp_hold = 2, rsp_wait = 0, rsp_held = 0;
    bit          inflight_arm = 0, wr_clr = 0;
    logic [31:0] log_lba[$];
    logic [3:0]  log_sec[$];

    task automatic tick();
        @(posedge CLK_VIDEO);
        model_step();
        @(negedge CLK_VIDEO);
        if (wr_clr) begin fd_write_disk = 1'b0; wr_clr = 0; end
        chk("dirty", 32'(dirty), 32'(m_dirty));
        chk("sd_wr", 32'(sd_wr), 32'(m_phase == 2));
        chk("cpu_wait", 32'(cpu_wait), 32'(m_phase != 0));
        chk("flush_done", 32'(flush_done), 32'(m_phase == 4));
        if (m_phase == 2 || m_phase == 3) begin
            chk("sd_lba", sd_lba, m_lba);
            chk("wb_sector", 32'(wb_sector), 32'(m_sec));
        end
        if (reset) begin
            sd_ack = 1'b0; rsp_wait = 0; rsp_held = 0;
        end else if (sd_ack) begin
            rsp_held++;
            if (rsp_held >= rsp_hold) begin sd_ack = 1'b0; rsp_held = 0; end
        end else if (sd_wr) begin
            rsp_wait++;
            if (rsp_wait >= rsp_delay) begin
                sd_ack = 1'b1; rsp_wait = 0;
                log_lba.push_back(sd_lba);
                log_sec.push_back(wb_sector);
                if (inflight_arm) begin
                    fd_write_disk = 1'b1;
                    fd_track_addr = 14'(m_sec) << 9;
                    inflight_arm  = 0;
                    wr_clr        = 1;
                end
            end
        end else begin
            rsp_wait = 0;
        end
    endtask

    task automatic write_addr(input logic [13:0] a);
        fd_write_disk = 1'b1; fd_track_addr = a;
        tick();
        fd_write_disk = 1'b0;
    endtask

    task automatic pulse_flush();
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
    endtask

    task automatic wait_flush(input int budget, output int dones);
        dones = 0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (flush_done) dones++;
            else if (dones > 0) return;
        end
        chk("flush_timeout", 32'(0), 32'(1));
    endtask

    task automatic ticks_to_wait(input int budget, output int n);
        n = 0;
        for (int i = 0; i < budget; i++) begin
            tick(); n++;
            if (cpu_wait) return;
        end
    endtask

    initial begin
        int d, n, busy;
        bit hit;
        reset = 1'b1; track = '0; fd_write_disk = 1'b0; fd_track_addr = '0;
        fdd_mounted = 1'b1; img_readonly = 1'b0; flush_req = 1'b0; sd_ack = 1'b0;
        tick(); tick();
        chk("rst_sd_lba", sd_lba, 32'd0);
        chk("rst_wb_sector", 32'(wb_sector), 32'd0);
        chk("rst_cpu_wait", 32'(cpu_wait), 32'd0);
        reset = 1'b0;
        tick();

        // clean flush: SCAN then DONE
        pulse_flush();
        chk("clean_scan_wait", 32'(cpu_wait), 32'd1);
        chk("clean_scan_done", 32'(flush_done), 32'd0);
        tick();
        chk("clean_done", 32'(flush_done), 32'd1);
        chk("clean_done_wait", 32'(cpu_wait), 32'd1);
        chk("clean_no_wr", 32'(sd_wr), 32'd0);
        tick();
        chk("clean_after", 32'(flush_done), 32'd0);
        chk("clean_after_wait", 32'(cpu_wait), 32'd0);

        // sectors 5 and 12 on track 3
        track = 6'd3;
        write_addr(14'h0A00);
        write_addr(14'h1800);
        chk("two_dirty", 32'(dirty), 32'h1020);
        log_lba.delete(); log_sec.delete();
        rsp_delay = 4;
        pulse_flush();
        wait_flush(200, d);
        chk("two_dones", 32'(d), 32'd1);
        chk("two_xfers", 32'(log_lba.size()), 32'd2);
        if (log_lba.size() == 2) begin
            chk("xfer0_lba", log_lba[0], 32'd44);
            chk("xfer0_sec", 32'(log_sec[0]), 32'd5);
            chk("xfer1_lba", log_lba[1], 32'd51);
            chk("xfer1_sec", 32'(log_sec[1]), 32'd12);
        end
        chk("two_clean", 32'(dirty), 32'd0);

        // sector 13 is outside the track
        write_addr(14'h1A00);
        chk("sec13_dirty", 32'(dirty), 32'd0);
        busy = 0;
        for (int i = 0; i < 20; i++) begin tick(); if (cpu_wait) busy++; end
        chk("sec13_no_fire", 32'(busy), 32'd0);

        // idle timer
        track = 6'd0;
        log_lba.delete(); log_sec.delete();
        write_addr(14'h0000);
        ticks_to_wait(30, n);
        chk("idle_latency", 32'(n), 32'd8);
        wait_flush(200, d);
        chk("idle_xfers", 32'(log_lba.size()), 32'd1);
        if (log_lba.size() == 1) chk("idle_lba", log_lba[0], 32'd0);
        write_addr(14'h0200);
        for (int i = 0; i < 5; i++) tick();
        chk("restart_no_fire", 32'(cpu_wait), 32'd0);
        write_addr(14'h0400);
        ticks_to_wait(30, n);
        chk("restart_latency", 32'(n), 32'd8);
        wait_flush(300, d);
        chk("restart_clean", 32'(dirty), 32'd0);

        // read-only image discards dirty data
        img_readonly = 1'b1;
        log_lba.delete(); log_sec.delete();
        write_addr(14'h0000);
        write_addr(14'h0200);
        chk("ro_dirty", 32'(dirty), 32'd3);
        pulse_flush();
        wait_flush(20, d);
        chk("ro_dones", 32'(d), 32'd1);
        chk("ro_no_xfer", 32'(log_lba.size()), 32'd0);
        chk("ro_clean", 32'(dirty), 32'd0);
        img_readonly = 1'b0;

        // reset in the middle of a transfer
        rsp_hold = 6;
        write_addr(14'h0800);
        pulse_flush();
        hit = 0;
        for (int i = 0; i < 50 && !hit; i++) begin tick(); if (m_phase == 3) hit = 1; end
        chk("reach_xfer", 32'(hit), 32'd1);
        reset = 1'b1; sd_ack = 1'b0;
        tick();
        chk("mid_rst_wr", 32'(sd_wr), 32'd0);
        chk("mid_rst_wait", 32'(cpu_wait), 32'd0);
        chk("mid_rst_dirty", 32'(dirty), 32'd0);
        chk("mid_rst_lba", sd_lba, 32'd0);
        reset = 1'b0; rsp_hold = 2;
        pulse_flush();
        chk("post_rst_scan", 32'(cpu_wait), 32'd1);
        tick();
        chk("post_rst_done", 32'(flush_done), 32'd1);
        tick();
        chk("post_rst_idle", 32'(cpu_wait), 32'd0);

        // controller rewrites the sector in flight on the ack edge
        log_lba.delete(); log_sec.delete();
        write_addr(14'h0E00);
        inflight_arm = 1;
        pulse_flush();
        wait_flush(300, d);
        chk("inflight_xfers", 32'(log_sec.size()), 32'd2);
        if (log_sec.size() == 2) begin
            chk("inflight_sec0", 32'(log_sec[0]), 32'd7);
            chk("inflight_sec1", 32'(log_sec[1]), 32'd7);
            chk("inflight_lba1", log_lba[1], 32'd7);
        end
        chk("inflight_clean", 32'(dirty), 32'd0);

        // random traffic against the model
        for (int i = 0; i < 1500; i++) begin
            if (!wr_clr) begin
                fd_write_disk = ($urandom_range(3) == 0);
                fd_track_addr = 14'($urandom);
            end
            flush_req    = ($urandom_range(15) == 0);
            track        = 6'($urandom);
            fdd_mounted  = ($urandom_range(9) != 0);
            img_readonly = ($urandom_range(9) == 0);
            reset        = ($urandom_range(199) == 0);
            if (reset) sd_ack = 1'b0;
            rsp_delay    = 1 + $urandom_range(3);
            rsp_hold     = 1 + $urandom_range(2);
            if ($urandom_range(7) == 0) inflight_arm = 1;
            tick();
        end
        reset = 1'b0; flush_req = 1'b0; img_readonly = 1'b0; fdd_mounted = 1'b1;
        inflight_arm = 0;
        if (!wr_clr) fd_write_disk = 1'b0;
        for (int i = 0; i < 300; i++) tick();
        chk("final_clean", 32'(dirty), 32'd0);
        chk("final_idle", 32'(cpu_wait), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
